// File: rtl/sclk_share_arbiter.sv
// sclk_share_arbiter: request/grant arbiter for the shared LCD serial clock.
// Two masters (LTM 3-wire config, touch ADC) share SCLK. A grant is only
// issued after a guard gap with SCLK parked, ownership is round-robin on
// ties, and a watchdog revokes a grant held longer than HOLD_MAX cycles.
module sclk_share_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned HOLD_MAX     = 4096,
  parameter int unsigned CNT_W        = 13,
  parameter logic        PARK_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_ltm,
  input  logic req_adc,
  input  logic ltm_sclk_in,
  input  logic ltm_scen_in,
  input  logic adc_dclk_in,
  input  logic adc_cs_n_in,
  input  logic clr_err,
  output logic gnt_ltm,
  output logic gnt_adc,
  output logic bus_sclk,
  output logic ltm_scen_out,
  output logic adc_cs_n_out,
  output logic busy,
  output logic timeout_ltm,
  output logic timeout_adc
);

  typedef enum logic [1:0] {
    IDLE,
    PRE_GUARD,
    OWN,
    POST_GUARD
  } state_t;

  typedef enum logic {
    OWNER_LTM,
    OWNER_ADC
  } owner_t;

  localparam logic [CNT_W-1:0] GUARD_LOAD =
    (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  owner_t           sel_q, sel_d;
  owner_t           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_ltm_q, gnt_ltm_d;
  logic             gnt_adc_q, gnt_adc_d;
  logic             to_ltm_q, to_ltm_d;
  logic             to_adc_q, to_adc_d;
  logic             lock_ltm_q, lock_ltm_d;
  logic             lock_adc_q, lock_adc_d;

  logic             elig_ltm, elig_adc;
  logic             req_sel;
  owner_t           winner;

  // State register and all sticky/registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= OWNER_LTM;
      last_q     <= OWNER_ADC;
      cnt_q      <= '0;
      gnt_ltm_q  <= 1'b0;
      gnt_adc_q  <= 1'b0;
      to_ltm_q   <= 1'b0;
      to_adc_q   <= 1'b0;
      lock_ltm_q <= 1'b0;
      lock_adc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      gnt_ltm_q  <= gnt_ltm_d;
      gnt_adc_q  <= gnt_adc_d;
      to_ltm_q   <= to_ltm_d;
      to_adc_q   <= to_adc_d;
      lock_ltm_q <= lock_ltm_d;
      lock_adc_q <= lock_adc_d;
    end
  end

  // Next-state logic: arbitration, guard/hold counting, watchdog and flags.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    // A locked-out master is released as soon as it drops its request.
    lock_ltm_d = lock_ltm_q & req_ltm;
    lock_adc_d = lock_adc_q & req_adc;
    to_ltm_d   = clr_err ? 1'b0 : to_ltm_q;
    to_adc_d   = clr_err ? 1'b0 : to_adc_q;

    elig_ltm = req_ltm & ~lock_ltm_q;
    elig_adc = req_adc & ~lock_adc_q;
    req_sel  = (sel_q == OWNER_ADC) ? req_adc : req_ltm;

    if (elig_ltm && elig_adc) begin
      winner = (last_q == OWNER_LTM) ? OWNER_ADC : OWNER_LTM;
    end else if (elig_adc) begin
      winner = OWNER_ADC;
    end else begin
      winner = OWNER_LTM;
    end

    unique case (state_q)
      IDLE: begin
        if (elig_ltm || elig_adc) begin
          sel_d = winner;
          if (GUARD_CYCLES > 0) begin
            state_d = PRE_GUARD;
            cnt_d   = GUARD_LOAD;
          end else begin
            state_d = OWN;
            cnt_d   = '0;
          end
        end
      end
      PRE_GUARD: begin
        if (!req_sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = OWN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OWN: begin
        if (!req_sel || cnt_q == HOLD_LAST) begin
          // Forced revoke only when the owner is still requesting; the
          // timeout set is applied after the clear so it wins a collision.
          if (req_sel) begin
            if (sel_q == OWNER_ADC) begin
              to_adc_d   = 1'b1;
              lock_adc_d = 1'b1;
            end else begin
              to_ltm_d   = 1'b1;
              lock_ltm_d = 1'b1;
            end
          end
          last_d = sel_q;
          if (GUARD_CYCLES > 0) begin
            state_d = POST_GUARD;
            cnt_d   = GUARD_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      POST_GUARD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Grants are a registered image of the next state, so they rise on the
    // same edge that enters OWN and fall on the edge that leaves it.
    gnt_ltm_d = (state_d == OWN) && (sel_d == OWNER_LTM);
    gnt_adc_d = (state_d == OWN) && (sel_d == OWNER_ADC);
  end

  // Pin mux; the grant only changes while both masters are parked.
  always_comb begin
    bus_sclk     = PARK_LEVEL;
    ltm_scen_out = 1'b1;
    adc_cs_n_out = 1'b1;
    if (gnt_ltm_q) begin
      bus_sclk     = ltm_sclk_in;
      ltm_scen_out = ltm_scen_in;
    end else if (gnt_adc_q) begin
      bus_sclk     = adc_dclk_in;
      adc_cs_n_out = adc_cs_n_in;
    end
  end

  assign gnt_ltm     = gnt_ltm_q;
  assign gnt_adc     = gnt_adc_q;
  assign busy        = (state_q != IDLE);
  assign timeout_ltm = to_ltm_q;
  assign timeout_adc = to_adc_q;

endmodule
